// File: rtl/lif_neuron_array_if.sv
// lif_neuron_array_if
//   Bundles the data/control pins of lif_neuron_array so the array and its
//   driver share one definition of widths and directions.
//   master : drives enable, current, threshold, sel; observes the outputs
//   slave  : the neuron array itself
//   Signals:
//     enable     - scan advances one neuron per clk when high
//     current    - input current for the neuron being updated
//     threshold  - firing threshold, sampled at each neuron update
//     sel        - neuron whose membrane appears on state_out
//     spike      - latest registered spike result per neuron
//     state_out  - membrane of neuron sel (combinational)
//     frame_done - one-cycle pulse after the last neuron updates
interface lif_neuron_array_if #(
    parameter int N_NEURONS = 8,
    parameter int WIDTH     = 8
);
    localparam int SEL_W = $clog2(N_NEURONS);

    logic                 enable;
    logic [WIDTH-1:0]     current;
    logic [WIDTH-1:0]     threshold;
    logic [SEL_W-1:0]     sel;
    logic [N_NEURONS-1:0] spike;
    logic [WIDTH-1:0]     state_out;
    logic                 frame_done;

    modport master (
        output enable, current, threshold, sel,
        input  spike, state_out, frame_done
    );

    modport slave (
        input  enable, current, threshold, sel,
        output spike, state_out, frame_done
    );
endinterface

// File: rtl/lif_neuron_array.sv
// lif_neuron_array
//   N_NEURONS leaky-integrate-and-fire neurons sharing one time-multiplexed
//   update datapath. Membrane and refractory state live in register files;
//   one neuron (scan index idx) is updated per enabled clock, so a frame is
//   N_NEURONS enabled cycles.
//   Ports:
//     clk, rst_n - clock, asynchronous active-low reset
//     bus        - lif_neuron_array_if.slave (enable, current, threshold,
//                  sel in; spike, state_out, frame_done out)
//   Optional feature:
//     LIF_CHAIN_EN - when defined, neuron i>0 additionally receives
//                    CHAIN_WEIGHT if neuron i-1 spiked (its registered result,
//                    i.e. from this frame since i-1 updates first).

// Single-neuron update rule: refractory hold, leak + integrate with
// saturation, threshold compare.
module lif_update #(
    parameter int WIDTH          = 8,
    parameter int LEAK_SHIFT     = 1,
    parameter int REFRAC_UPDATES = 2,
    parameter int RW             = 2
) (
    input  logic [WIDTH-1:0] mem,
    input  logic [RW-1:0]    refrac,
    input  logic [WIDTH+1:0] in_val,
    input  logic [WIDTH-1:0] threshold,
    output logic [WIDTH-1:0] mem_nxt,
    output logic [RW-1:0]    refrac_nxt,
    output logic             spike_nxt
);
    localparam logic [WIDTH+1:0] SAT_MAX = {2'b00, {WIDTH{1'b1}}};

    logic [WIDTH-1:0] leak;
    logic [WIDTH+1:0] sum;
    logic [WIDTH-1:0] sat;

    always_comb begin
        leak = mem >> LEAK_SHIFT;
        // mem - leak never underflows, so only the upper end needs clamping.
        sum  = {2'b00, mem} - {2'b00, leak} + in_val;
        sat  = (sum > SAT_MAX) ? {WIDTH{1'b1}} : sum[WIDTH-1:0];

        mem_nxt    = mem;
        refrac_nxt = refrac;
        spike_nxt  = 1'b0;
        if (refrac != '0) begin
            mem_nxt    = '0;
            refrac_nxt = refrac - RW'(1);
        end else if (sat >= threshold) begin
            mem_nxt    = '0;
            refrac_nxt = RW'(REFRAC_UPDATES);
            spike_nxt  = 1'b1;
        end else begin
            mem_nxt    = sat;
        end
    end
endmodule

module lif_neuron_array #(
    parameter int N_NEURONS      = 8,
    parameter int WIDTH          = 8,
    parameter int LEAK_SHIFT     = 1,
    parameter int REFRAC_UPDATES = 2,
    parameter int CHAIN_WEIGHT   = 64
) (
    input  logic               clk,
    input  logic               rst_n,
    lif_neuron_array_if.slave  bus
);
    localparam int IDX_W = $clog2(N_NEURONS);
    localparam int RW    = (REFRAC_UPDATES > 0) ? $clog2(REFRAC_UPDATES + 1) : 1;
    localparam int SUM_W = WIDTH + 2;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_NEURONS - 1);

`ifdef LIF_CHAIN_EN
    localparam bit CHAIN_ON = 1'b1;
`else
    localparam bit CHAIN_ON = 1'b0;
`endif

    logic [IDX_W-1:0]                idx_q, idx_d;
    logic [N_NEURONS-1:0][WIDTH-1:0] mem_q, mem_d;
    logic [N_NEURONS-1:0][RW-1:0]    refrac_q, refrac_d;
    logic [N_NEURONS-1:0]            spike_q, spike_d;
    logic                            frame_done_q, frame_done_d;

    logic             prev_spike;
    logic [SUM_W-1:0] in_val;
    logic [WIDTH-1:0] upd_mem;
    logic [RW-1:0]    upd_refrac;
    logic             upd_spike;

    // Lateral input: upstream neuron's registered spike. Neuron 0 has no
    // upstream, and the chain term is zero unless the feature is built in.
    always_comb begin
        prev_spike = 1'b0;
        if (idx_q != '0)
            prev_spike = spike_q[idx_q - IDX_W'(1)];
        in_val = {2'b00, bus.current};
        if (CHAIN_ON && prev_spike)
            in_val = in_val + SUM_W'(CHAIN_WEIGHT);
    end

    lif_update #(
        .WIDTH          (WIDTH),
        .LEAK_SHIFT     (LEAK_SHIFT),
        .REFRAC_UPDATES (REFRAC_UPDATES),
        .RW             (RW)
    ) u_update (
        .mem        (mem_q[idx_q]),
        .refrac     (refrac_q[idx_q]),
        .in_val     (in_val),
        .threshold  (bus.threshold),
        .mem_nxt    (upd_mem),
        .refrac_nxt (upd_refrac),
        .spike_nxt  (upd_spike)
    );

    always_comb begin
        idx_d        = idx_q;
        mem_d        = mem_q;
        refrac_d     = refrac_q;
        spike_d      = spike_q;
        frame_done_d = 1'b0;
        if (bus.enable) begin
            mem_d[idx_q]    = upd_mem;
            refrac_d[idx_q] = upd_refrac;
            spike_d[idx_q]  = upd_spike;
            frame_done_d    = (idx_q == IDX_LAST);
            idx_d           = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q        <= '0;
            mem_q        <= '0;
            refrac_q     <= '0;
            spike_q      <= '0;
            frame_done_q <= 1'b0;
        end else begin
            idx_q        <= idx_d;
            mem_q        <= mem_d;
            refrac_q     <= refrac_d;
            spike_q      <= spike_d;
            frame_done_q <= frame_done_d;
        end
    end

    // Readout; sel codes past the last neuron (non-power-of-2 N) read 0.
    always_comb begin
        bus.state_out = '0;
        if (32'(bus.sel) < N_NEURONS)
            bus.state_out = mem_q[bus.sel];
    end

    assign bus.spike      = spike_q;
    assign bus.frame_done = frame_done_q;
endmodule

// File: tb/tb_lif_neuron_array.sv
// Directed bench for lif_neuron_array (N=8, WIDTH=8, LEAK_SHIFT=1, REFRAC=2).
module tb_lif_neuron_array;
    logic clk;
    logic rst_n;

    lif_neuron_array_if #(.N_NEURONS(8), .WIDTH(8)) bus ();

    lif_neuron_array #(
        .N_NEURONS(8), .WIDTH(8), .LEAK_SHIFT(1),
        .REFRAC_UPDATES(2), .CHAIN_WEIGHT(64)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [7:0] cur;
        logic [7:0] thr;
        logic [7:0] exp_spike;
        logic [7:0] exp_mem;   // every neuron holds this membrane after the frame
    } frame_vec_t;

    frame_vec_t vecs [16];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_mem(input string tag, input int first, input int last, input logic [7:0] exp);
        for (int j = first; j <= last; j++) begin
            bus.sel = 3'(j);
            #1;
            chk($sformatf("%s mem[%0d]", tag, j), 32'(bus.state_out), 32'(exp));
        end
    endtask

    initial begin
        logic [7:0] fd_mask;
        logic       fd_any;
        logic [7:0] exp_n1;

        rst_n      = 1'b0;
        bus.enable = 1'b0;
        bus.current = '0;
        bus.threshold = '0;
        bus.sel    = '0;
        #1;
        chk("reset spike", 32'(bus.spike), 32'h0);
        chk("reset frame_done", 32'(bus.frame_done), 32'h0);
        check_mem("reset", 0, 1, 8'd0);
        #3 rst_n = 1'b1;

        // Integrate/fire/refractory, then saturation, then threshold=0.
        vecs[0]  = '{8'd150, 8'd200, 8'h00, 8'd150};
        vecs[1]  = '{8'd150, 8'd200, 8'hFF, 8'd0};
        vecs[2]  = '{8'd150, 8'd200, 8'h00, 8'd0};
        vecs[3]  = '{8'd150, 8'd200, 8'h00, 8'd0};
        vecs[4]  = '{8'd150, 8'd200, 8'h00, 8'd150};
        vecs[5]  = '{8'd150, 8'd200, 8'hFF, 8'd0};
        vecs[6]  = '{8'd200, 8'd255, 8'h00, 8'd0};
        vecs[7]  = '{8'd200, 8'd255, 8'h00, 8'd0};
        vecs[8]  = '{8'd200, 8'd255, 8'h00, 8'd200};
        vecs[9]  = '{8'd200, 8'd255, 8'hFF, 8'd0};   // 100+200=300 -> 255
        vecs[10] = '{8'd0,   8'd0,   8'h00, 8'd0};
        vecs[11] = '{8'd0,   8'd0,   8'h00, 8'd0};
        vecs[12] = '{8'd0,   8'd0,   8'hFF, 8'd0};   // threshold 0 fires
        vecs[13] = '{8'd0,   8'd0,   8'h00, 8'd0};
        vecs[14] = '{8'd0,   8'd0,   8'h00, 8'd0};
        vecs[15] = '{8'd0,   8'd0,   8'hFF, 8'd0};

        bus.enable = 1'b1;
        for (int f = 0; f < 16; f++) begin
            bus.current   = vecs[f].cur;
            bus.threshold = vecs[f].thr;
            fd_mask = '0;
            for (int c = 0; c < 8; c++) begin
                step();
                fd_mask[c] = bus.frame_done;
            end
            chk($sformatf("frame%0d frame_done", f + 1), 32'(fd_mask), 32'h80);
            chk($sformatf("frame%0d spike", f + 1), 32'(bus.spike), 32'(vecs[f].exp_spike));
            check_mem($sformatf("frame%0d", f + 1), 0, 7, vecs[f].exp_mem);
        end

        // Mid-frame asynchronous reset: neurons 0..2 refractory-cleared, rest still 1.
        bus.current   = 8'd150;
        bus.threshold = 8'd200;
        for (int c = 0; c < 3; c++) step();
        chk("pre-reset spike", 32'(bus.spike), 32'hF8);
        #4 rst_n = 1'b0;
        #1;
        chk("async reset spike", 32'(bus.spike), 32'h0);
        chk("async reset frame_done", 32'(bus.frame_done), 32'h0);
        check_mem("async reset", 0, 3, 8'd0);
        #1 rst_n = 1'b1;

        step();
        check_mem("post-reset first", 0, 0, 8'd150);
        check_mem("post-reset untouched", 1, 1, 8'd0);
        step();
        step();

        // Enable gating for 5 cycles mid-frame.
        bus.enable = 1'b0;
        fd_any = 1'b0;
        for (int c = 0; c < 5; c++) begin
            step();
            fd_any |= bus.frame_done;
        end
        chk("gated frame_done", 32'(fd_any), 32'h0);
        chk("gated spike", 32'(bus.spike), 32'h0);
        check_mem("gated done", 2, 2, 8'd150);
        check_mem("gated pending", 3, 3, 8'd0);
        bus.enable = 1'b1;
        fd_mask = '0;
        for (int c = 0; c < 5; c++) begin
            step();
            fd_mask[c] = bus.frame_done;
        end
        chk("gated late frame_done", 32'(fd_mask), 32'h10);
        check_mem("gated resumed", 3, 7, 8'd150);

        // Lateral chain: force neuron 0 to spike, then raise threshold.
        @(posedge clk);
        #2 rst_n = 1'b0;
        #2 rst_n = 1'b1;
        bus.current   = 8'd100;
        bus.threshold = 8'd100;
        step();
        bus.threshold = 8'd200;
        step();
        step();
`ifdef LIF_CHAIN_EN
        exp_n1 = 8'd164;
`else
        exp_n1 = 8'd100;
`endif
        chk("chain spike", 32'(bus.spike), 32'h01);
        check_mem("chain n1", 1, 1, exp_n1);
        check_mem("chain n2", 2, 2, 8'd100);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
